// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings and operation codes for the two-port memory arbiter.
// Revision 1.0
`default_nettype none

package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_ACCESS    = 2'd1;
  localparam state_t ST_READ_WAIT = 2'd2;
  localparam state_t ST_RESP      = 2'd3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker with its own last-grant register.
// Revision 1.0
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_idx,
  output logic       grant_idx
);
  import mem_arb_pkg::*;

  logic last_grant;

  // Resetting to 1 makes requester 0 the winner of the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= update_idx;
    end
  end

  always_comb begin
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving two requesters single-beat access to a synchronous memory.
// Revision 1.0
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_done,
  output logic              req1_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_arb_pkg::*;

  state_t state;
  state_t state_nxt;
  logic   wr_q;
  logic   grant_q;
  logic   grant_idx;
  logic   any_valid;
  logic   accept;

  assign any_valid = req0_valid | req1_valid;
  assign accept    = (state == ST_IDLE) && any_valid;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .reset      (reset),
    .req        ({req1_valid, req0_valid}),
    .update     (state == ST_RESP),
    .update_idx (grant_q),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request fields are captured only at the grant, so later changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q      <= OP_READ;
      grant_q   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
    end else begin
      if (accept) begin
        grant_q   <= grant_idx;
        wr_q      <= grant_idx ? req1_wr    : req0_wr;
        mem_addr  <= grant_idx ? req1_addr  : req0_addr;
        mem_wdata <= grant_idx ? req1_wdata : req0_wdata;
      end
      if (state == ST_READ_WAIT) begin
        rd_data <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (any_valid) state_nxt = ST_ACCESS;
      ST_ACCESS:    state_nxt = (wr_q == OP_WRITE) ? ST_RESP : ST_READ_WAIT;
      ST_READ_WAIT: state_nxt = ST_RESP;
      ST_RESP:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    mem_en    = 1'b0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    req0_done = 1'b0;
    req1_done = 1'b0;
    if (state == ST_ACCESS) begin
      mem_en    = 1'b1;
      mem_wr_en = (wr_q == OP_WRITE);
      mem_rd_en = (wr_q == OP_READ);
    end
    if (state == ST_RESP) begin
      req0_done = ~grant_q;
      req1_done = grant_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level model checked every cycle.
// Revision 1.0
`default_nettype none

module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_wr = 1'b0;
  logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_wr = 1'b0;
  logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
  logic       req0_done, req1_done, busy, mem_en, mem_wr_en, mem_rd_en;
  logic [7:0] rd_data, mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_done(req0_done), .req1_done(req1_done), .rd_data(rd_data), .busy(busy),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: read data appears the cycle after mem_rd_en.
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Transaction model: each accepted request occupies a fixed window of cycles.
  int         cyc = 0;
  bit         act = 1'b0;
  int         acc_c = 0, done_c = 0;
  bit         m_wr = 1'b0, m_g = 1'b0, m_lg = 1'b1;
  logic [7:0] e_addr = 8'h00, e_wdata = 8'h00, e_rd = 8'h00, m_rdval = 8'h00;
  logic [7:0] mm [256];
  initial for (int i = 0; i < 256; i++) mm[i] = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      act = 1'b0; m_lg = 1'b1; e_addr = 8'h00; e_wdata = 8'h00; e_rd = 8'h00;
    end else if ((!act || cyc > done_c) && (req0_valid || req1_valid)) begin
      m_g     = (req0_valid && req1_valid) ? !m_lg : req1_valid;
      m_lg    = m_g;
      m_wr    = m_g ? req1_wr : req0_wr;
      e_addr  = m_g ? req1_addr : req0_addr;
      e_wdata = m_g ? req1_wdata : req0_wdata;
      act     = 1'b1;
      acc_c   = cyc + 1;
      done_c  = m_wr ? cyc + 2 : cyc + 3;
      if (m_wr) mm[e_addr] = e_wdata;
      else m_rdval = mm[e_addr];
    end
    cyc++;
    if (act && cyc == done_c && !m_wr) e_rd = m_rdval;
    #1;
    chk("busy", busy, act && cyc >= acc_c && cyc <= done_c);
    chk("mem_en", mem_en, act && cyc == acc_c);
    chk("mem_wr_en", mem_wr_en, act && cyc == acc_c && m_wr);
    chk("mem_rd_en", mem_rd_en, act && cyc == acc_c && !m_wr);
    chk("req0_done", req0_done, act && cyc == done_c && !m_g);
    chk("req1_done", req1_done, act && cyc == done_c && m_g);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("rd_data", rd_data, e_rd);
  end

  task automatic drive(input bit idx, input bit v, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (idx) begin
      req1_valid = v; req1_wr = wr; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_wr = wr; req0_addr = a; req0_wdata = d;
    end
  endtask

  int order[$];

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_done", {req1_done, req0_done}, 0);
    reset = 1'b0;

    // Both requesters held high out of reset: expect alternating grants 0,1,0,1.
    drive(0, 1, 1, 8'h20, 8'h11);
    drive(1, 1, 1, 8'h21, 8'h22);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (req0_done) order.push_back(0);
      if (req1_done) order.push_back(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) chk("rr_order", order[i], i % 2);
    @(negedge clk);

    // Single write by requester 0.
    drive(0, 1, 1, 8'h12, 8'hA5);
    @(negedge clk);
    chk("wr_strobe", {mem_en, mem_wr_en, mem_rd_en}, 3'b110);
    chk("wr_addr", mem_addr, 8'h12);
    chk("wr_wdata", mem_wdata, 8'hA5);
    req0_valid = 1'b0;
    @(negedge clk);
    chk("wr_done", {req1_done, req0_done}, 2'b01);
    @(negedge clk);
    chk("wr_idle", busy, 0);

    // Single read by requester 1 of the value just written.
    drive(1, 1, 0, 8'h12, 8'h00);
    @(negedge clk);
    chk("rd_strobe", {mem_en, mem_wr_en, mem_rd_en}, 3'b101);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rd_wait_done", {req1_done, req0_done}, 2'b00);
    @(negedge clk);
    chk("rd_done", {req1_done, req0_done}, 2'b10);
    chk("rd_data_a5", rd_data, 8'hA5);
    @(negedge clk);

    // Requester 0 pulses valid only while the arbiter is busy: request withdrawn.
    drive(1, 1, 0, 8'h21, 8'h00);
    @(negedge clk);
    req1_valid = 1'b0;
    drive(0, 1, 1, 8'h30, 8'h77);
    @(negedge clk);
    req0_valid = 1'b0;
    for (int j = 3; j <= 8; j++) begin
      @(negedge clk);
      if (j == 3) begin
        chk("wd_req1_done", req1_done, 1);
        chk("wd_rd_data", rd_data, 8'h22);
      end
      chk("wd_no_req0_done", req0_done, 0);
      chk("wd_no_write", mem_wr_en, 0);
    end

    // Reset during READ_WAIT aborts the read.
    drive(0, 1, 0, 8'h12, 8'h00);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_strobes", {mem_en, mem_wr_en, mem_rd_en}, 3'b000);
    chk("ar_done", {req1_done, req0_done}, 2'b00);
    chk("ar_busy", busy, 0);
    chk("ar_rd_data", rd_data, 8'h00);
    chk("ar_mem_addr", mem_addr, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    drive(1, 1, 1, 8'h40, 8'h3C);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("post_wr_done", req1_done, 1);
    chk("post_wr_rd_keep", rd_data, 8'h00);
    @(negedge clk);
    drive(0, 1, 0, 8'h40, 8'h00);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rd_done", req0_done, 1);
    chk("post_rd_data", rd_data, 8'h3C);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
